// File: rtl/md_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : md_seq_ctrl
// Description : Sequential multiply/divide controller for HI/LO. Shift-add
//               multiply and restoring divide over WIDTH iterations, driving
//               one shared external combinational CLA once per cycle.
//               Optional signed MULT/DIV enabled by macro MD_SIGNED_EN; when
//               undefined, op[0] is ignored and every op is unsigned.
// Revision    : 1.0 - initial release
// ============================================================================
module md_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_PREP_A = 3'd1;
    localparam logic [2:0] c_PREP_B = 3'd2;
    localparam logic [2:0] c_ITER   = 3'd3;
    localparam logic [2:0] c_FIX_LO = 3'd4;
    localparam logic [2:0] c_FIX_HI = 3'd5;

    localparam logic [4:0] c_CNT_LAST = 5'(WIDTH - 1);

    logic [2:0]       r_state;
    logic [4:0]       r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_dz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_a;        // multiplicand / dividend (magnitude after PREP_A)
    logic [WIDTH-1:0] r_b;        // multiplier / divisor (magnitude after PREP_B)
    logic [WIDTH-1:0] r_acc_hi;   // P_hi for multiply, remainder R for divide
    logic [WIDTH-1:0] r_acc_lo;   // P_lo for multiply, quotient Q for divide
    logic             r_is_div;
    logic             r_neg_a;
    logic             r_neg_b;
    logic             r_dz_pend;
    logic             r_carry;    // carry out of the LO negation pass

    logic             w_signed;
    logic [WIDTH-1:0] w_rem_shift;
    logic             w_neg_lo;
    logic             w_neg_hi;
    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_add_b;
    logic             w_add_cin;

`ifdef MD_SIGNED_EN
    assign w_signed = op[0];
`else
    // op[0] has no meaning in the unsigned-only build
    assign w_signed = 1'b0 & op[0];
`endif

    assign w_rem_shift = {r_acc_hi[WIDTH-2:0], r_acc_lo[WIDTH-1]};
    // Divide by zero bypasses all sign fixing
    assign w_neg_lo    = ~r_dz_pend & (r_neg_a ^ r_neg_b);
    assign w_neg_hi    = ~r_dz_pend & (r_is_div ? r_neg_a : (r_neg_a ^ r_neg_b));

    assign busy    = r_busy;
    assign done    = r_done;
    assign dz      = r_dz;
    assign hi      = r_hi;
    assign lo      = r_lo;
    assign add_a   = w_add_a;
    assign add_b   = w_add_b;
    assign add_cin = w_add_cin;

    // Adder operand steering: one use of the shared CLA per state, quiet in IDLE/reset
    always_comb begin
        w_add_a   = '0;
        w_add_b   = '0;
        w_add_cin = 1'b0;
        if (!rst) begin
            case (r_state)
                c_PREP_A: begin
                    w_add_a   = ~r_a;
                    w_add_cin = 1'b1;
                end
                c_PREP_B: begin
                    w_add_a   = ~r_b;
                    w_add_cin = 1'b1;
                end
                c_ITER: begin
                    if (r_is_div) begin
                        w_add_a   = w_rem_shift;
                        w_add_b   = ~r_b;
                        w_add_cin = 1'b1;
                    end else begin
                        w_add_a = r_acc_hi;
                        w_add_b = r_acc_lo[0] ? r_a : '0;
                    end
                end
                c_FIX_LO: begin
                    w_add_a   = ~r_acc_lo;
                    w_add_cin = 1'b1;
                end
                c_FIX_HI: begin
                    w_add_a   = ~r_acc_hi;
                    w_add_cin = r_is_div ? 1'b1 : r_carry;
                end
                default: ;
            endcase
        end
    end

    // Control FSM and datapath registers; hi/lo commit only on FIX_HI -> IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dz      <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_is_div  <= 1'b0;
            r_neg_a   <= 1'b0;
            r_neg_b   <= 1'b0;
            r_dz_pend <= 1'b0;
            r_carry   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        // start has priority over a simultaneous MTHI/MTLO
                        r_state   <= c_PREP_A;
                        r_busy    <= 1'b1;
                        r_dz      <= 1'b0;
                        r_is_div  <= op[1];
                        r_neg_a   <= w_signed & opa[WIDTH-1];
                        r_neg_b   <= w_signed & opb[WIDTH-1];
                        r_dz_pend <= op[1] & (opb == '0);
                        r_a       <= opa;
                        r_b       <= opb;
                    end else begin
                        if (hi_we) r_hi <= wdata;
                        if (lo_we) r_lo <= wdata;
                    end
                end
                c_PREP_A: begin
                    // raw dividend is kept on divide-by-zero, it becomes HI
                    if (r_neg_a && !r_dz_pend) r_a <= add_sum;
                    r_state <= c_PREP_B;
                end
                c_PREP_B: begin
                    if (r_neg_b) r_b <= add_sum;
                    r_acc_hi <= '0;
                    r_acc_lo <= r_is_div ? r_a : (r_neg_b ? add_sum : r_b);
                    r_cnt    <= '0;
                    r_state  <= c_ITER;
                end
                c_ITER: begin
                    if (r_is_div) begin
                        if (r_acc_hi[WIDTH-1] | add_cout) begin
                            r_acc_hi <= add_sum;
                            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_acc_hi <= w_rem_shift;
                            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        {r_acc_hi, r_acc_lo} <= {add_cout, add_sum, r_acc_lo[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == c_CNT_LAST) r_state <= c_FIX_LO;
                end
                c_FIX_LO: begin
                    r_carry <= add_cout;
                    if (w_neg_lo) r_acc_lo <= add_sum;
                    r_state <= c_FIX_HI;
                end
                c_FIX_HI: begin
                    r_hi    <= r_dz_pend ? r_a : (w_neg_hi ? add_sum : r_acc_hi);
                    r_lo    <= r_acc_lo;
                    r_dz    <= r_dz_pend;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_seq_ctrl
// Description : Self-checking bench for md_seq_ctrl: directed vector table,
//               multi-cycle corner sequences and randomized operations checked
//               against an arithmetic reference model. Honors MD_SIGNED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_seq_ctrl;

`ifdef MD_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          poke;
    } vec_t;

    vec_t vecs[10];

    md_seq_ctrl #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .dz       (dz),
        .hi       (hi),
        .lo       (lo),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // External CLA stand-in
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result {dz, hi, lo} from the arithmetic definition of each op
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic               sgn;
        logic        [63:0] p;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        longint             q;
        longint             r;
        sgn = SIGNED_EN && o[0];
        sa  = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        sb  = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        if (!o[1]) begin
            p = sa * sb;
            return {1'b0, p};
        end
        if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    // Launch one operation from an IDLE cycle, run to done; a second start is
    // pulsed on busy cycle 'poke' (0 = none) and must be ignored
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int poke, output logic [31:0] rh, output logic [31:0] rl,
                         output logic rdz, output int lat, output int nbusy);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 2'($urandom);
        opa   = $urandom;
        opb   = $urandom;
        check("busy_after_accept", {63'b0, busy}, 64'd1);
        check("dz_clear_on_start", {63'b0, dz}, 64'd0);
        lat   = 1;
        nbusy = 0;
        while (!done && lat < 100) begin
            if (busy) nbusy++;
            start = (lat == poke);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        rh    = hi;
        rl    = lo;
        rdz   = dz;
    endtask

    task automatic run_vec(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi,
                           input logic [31:0] elo, input logic edz, input int poke);
        logic [31:0] rh;
        logic [31:0] rl;
        logic        rdz;
        int          lat;
        int          nbusy;
        do_op(o, a, b, poke, rh, rl, rdz, lat, nbusy);
        check({tag, "_latency"}, 64'(lat), 64'd37);
        check({tag, "_busy_cycles"}, 64'(nbusy), 64'd36);
        check({tag, "_hi"}, {32'b0, rh}, {32'b0, ehi});
        check({tag, "_lo"}, {32'b0, rl}, {32'b0, elo});
        check({tag, "_dz"}, {63'b0, rdz}, {63'b0, edz});
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [64:0] exp_r;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          cyc;
        int          seen_done;
        int          seen_busy;

        vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0};
`ifdef MD_SIGNED_EN
        vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 5};
        vecs[2] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0};
        vecs[6] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 0};
`else
        vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0, 5};
        vecs[2] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0, 0};
        vecs[6] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 0};
`endif
        vecs[3] = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 36};
        vecs[4] = '{2'b10, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 0};
        vecs[5] = '{2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 0};
        vecs[7] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 0};
        vecs[8] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 0};
        vecs[9] = '{2'b00, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0, 0};

        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        opa   = '0;
        opb   = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_dz", {63'b0, dz}, 64'd0);
        check("reset_hi", {32'b0, hi}, 64'd0);
        check("reset_lo", {32'b0, lo}, 64'd0);
        check("reset_adder", {31'b0, add_a, add_cin}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_adder", {add_a, add_b}, 64'd0);

        // MTHI / MTLO in IDLE
        hi_we = 1'b1; wdata = 32'hA5A5_0001;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5A5A_0002;
        @(posedge clk); #1;
        lo_we = 1'b0;
        check("mthi", {32'b0, hi}, 64'h0000_0000_A5A5_0001);
        check("mtlo", {32'b0, lo}, 64'h0000_0000_5A5A_0002);

        // Directed table; each op starts in the done cycle of the previous one
        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].hi, vecs[i].lo, vecs[i].dz, vecs[i].poke);
        end
        @(posedge clk); #1;
        check("done_pulse_width", {62'b0, done, busy}, 64'd0);

        // Start with hi_we/lo_we held through the whole op: operation result wins
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_1234;
        run_vec("start_vs_write", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 0);
        hi_we = 1'b0; lo_we = 1'b0;
        @(posedge clk); #1;
        check("hold_after_op_hi", {32'b0, hi}, 64'd0);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            ro    = 2'($urandom_range(0, 3));
            ra    = pick_operand();
            rb    = pick_operand();
            exp_r = model(ro, ra, rb);
            run_vec($sformatf("rnd%0d_op%0d_%h_%h", i, ro, ra, rb), ro, ra, rb,
                    exp_r[63:32], exp_r[31:0], exp_r[64], 0);
        end
        @(posedge clk); #1;

        // Abort: extra start while busy, then reset on busy cycle 10
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_0055;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        start = 1'b1; op = 2'b00; opa = 32'd7; opb = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (cyc < 10) begin
            start = (cyc == 3);
            op    = 2'b10;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("abort_busy_before", {63'b0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        check("abort_adder_in_reset", {31'b0, add_a, add_cin}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        seen_done = 0;
        seen_busy = 0;
        for (int k = 0; k < 45; k++) begin
            if (done) seen_done++;
            if (busy) seen_busy++;
            @(posedge clk); #1;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);
        check("abort_no_second_op", 64'(seen_busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_seq_ctrl.md
MD_SEQ_CTRL -- requirements
Module: md_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width and iteration count; only 32 is supported, matching the shared CLA adder.
REQ-002 SHALL have clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have start  in  1  operation request, sampled only when busy=0.
REQ-005 SHALL have op  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have opa, opb  in  32 each  rs/rt operands; opa is the multiplicand or dividend, opb the multiplier or divisor.
REQ-007 SHALL have hi_we, lo_we  in  1 each, and wdata  in  32  MTHI/MTLO writes.
REQ-008 SHALL have busy  out  1, done  out  1, dz  out  1 (divide by zero), hi  out  32, lo  out  32.
REQ-009 SHALL have add_a, add_b  out  32, add_cin  out  1, add_sum  in  32, add_cout  in  1  port to the external 32-bit CLA, which is the only adder used; the CLA is combinational and is used once per cycle.

Function
REQ-010 States SHALL be IDLE, PREP_A, PREP_B, ITER, FIX_LO, FIX_HI, with IDLE->PREP_A on start accepted.
REQ-011 State sequence SHALL be PREP_A->PREP_B->ITER (exactly WIDTH cycles, internal 5-bit counter)->FIX_LO->FIX_HI->IDLE.
REQ-012 busy SHALL be 1 in every state except IDLE, so busy is high for exactly WIDTH+4=36 cycles.
REQ-013 Latency SHALL be fixed, independent of op and operand values; negation not needed in PREP/FIX still occupies its cycle with results discarded.
REQ-014 Operands SHALL be latched on the accept edge; later changes to opa/opb/op have no effect.
REQ-015 PREP_A/PREP_B SHALL produce |opa| / |opb| for signed ops with a negative operand, using add_a=~x, add_b=0, add_cin=1.
REQ-016 ITER for a multiply SHALL use add_a=P_hi, add_b=(P_lo[0] ? mcand : 0), add_cin=0, then {P_hi,P_lo} <= {add_cout,add_sum,P_lo[31:1]}, with P_hi initialised to 0 and P_lo to the multiplier.
REQ-017 ITER for a divide (restoring) SHALL form R'={R[30:0],Q[31]} and use add_a=R', add_b=~D, add_cin=1.
REQ-018 In each divide step, if (R[31] | add_cout) then R<=add_sum and the new Q LSB is 1, else R<=R' and the new Q LSB is 0; Q shifts left each step.
REQ-019 For a multiply, FIX_LO/FIX_HI SHALL negate the 64-bit product when the operand signs differ: LO first, then HI with add_cin = carry out of the LO pass.
REQ-020 For a divide, FIX_LO SHALL negate Q when the signs differ, and FIX_HI SHALL negate R when the dividend is negative.
REQ-021 hi/lo SHALL update only on the FIX_HI->IDLE edge: multiply gives HI=product[63:32], LO=product[31:0]; divide gives HI=remainder, LO=quotient.
REQ-022 done SHALL be a 1-cycle pulse in the first IDLE cycle after an operation, and a new start is accepted in that same cycle.
REQ-023 Divide by zero SHALL skip sign fixing and give LO=32'hFFFF_FFFF and HI=raw opa; dz is set with done and held until the next accepted start.
REQ-024 A start while busy=1 SHALL be ignored and not queued.
REQ-025 hi_we/lo_we SHALL write wdata only in IDLE and are ignored while busy.
REQ-026 If start and a write occur in the same IDLE cycle, start SHALL win and the write is dropped.
REQ-027 Overflow (e.g. 0x80000000 / -1 signed) SHALL NOT be flagged; the result is what the algorithm produces.

Reset
REQ-028 With rst=1 at a clock edge, the block SHALL go to IDLE with hi=lo=0 and busy=done=dz=0, aborting any operation in progress without a done pulse.
REQ-029 add_a, add_b and add_cin SHALL be 0 in IDLE and during reset.

Configuration
REQ-030 With macro MD_SIGNED_EN defined, MULT/DIV SHALL use signed two's-complement semantics per REQ-015 to REQ-020.
REQ-031 Without MD_SIGNED_EN, op[0] SHALL be ignored, all ops are unsigned, PREP/FIX remain pass cycles, and latency is unchanged.

Verification
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF SHALL give done on cycle 37 after the accept edge with HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 MULT 0xFFFFFFFD x 0x00000005 SHALL give HI=0xFFFFFFFF, LO=0xFFFFFFF1 with MD_SIGNED_EN, and HI=0x00000004, LO=0xFFFFFFF1 without it.
REQ-034 DIV 0xFFFFFFF9 / 0x00000002 with MD_SIGNED_EN SHALL give LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 SHALL give LO=14, HI=2.
REQ-035 DIVU 0x64 / 0 SHALL give dz=1, LO=0xFFFFFFFF, HI=0x00000064, with dz clearing on the next start.
REQ-036 Start while busy, then rst at the 10th busy cycle, SHALL result in busy=0 the next cycle, hi=lo=0, no done pulse, and the second start never executing.
REQ-037 start with hi_we=1 and wdata=0x1234 in IDLE SHALL leave HI set by the operation, not 0x1234, and hi_we while busy SHALL have no effect.
